bus_master: RTL and testbench
=============================

BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 The module SHALL have parameter WAIT_CYCLES, default 0, giving the number of extra cycles bSel is held before read data is sampled (range 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted this cycle when high together with req_valid.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-justified.
REQ-009 req_size  input  2  00 word, 01 half-word, 10 byte, 11 illegal.
REQ-010 req_signed  input  1  sign-extend load result (used only with LOAD_SIGNEXT_EN).
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result, valid with resp_valid.
REQ-013 resp_err  output  1  request rejected (misaligned or illegal size), valid with resp_valid.
REQ-014 bSel, bWrite  output  1 each  bus select and write strobe.
REQ-015 bAddr, bWData  output  32 each  bus address and write data.
REQ-016 mem_size  output  2  bus access size, same encoding as req_size.
REQ-017 bRData  input  32  combinational read data from selected slave, right-justified.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 On acceptance in IDLE, request fields SHALL be registered; a legal request SHALL go to ACCESS, an illegal one directly to RESP with resp_err=1.
REQ-020 Illegal SHALL mean: req_size=11, or half-word with req_addr[0]=1, or word with req_addr[1:0]!=00; illegal requests SHALL never assert bSel.
REQ-021 In ACCESS, bSel=1, bWrite=registered req_write, bAddr/mem_size from registered request, for exactly WAIT_CYCLES+1 cycles, counted by a 4-bit counter.
REQ-022 bWData SHALL be: word = wdata; half = {wdata[15:0], wdata[15:0]}; byte = wdata[7:0] replicated four times.
REQ-023 In the last ACCESS cycle of a load, bRData SHALL be captured and masked: byte keeps [7:0], half keeps [15:0], upper bits zero; word unmodified.
REQ-024 RESP SHALL last one cycle with resp_valid=1, then return to IDLE; back-to-back requests: accept at cycle T, bSel cycles T+1..T+1+WAIT_CYCLES, resp_valid at T+2+WAIT_CYCLES, next accept same cycle as RESP+1.
REQ-025 Outside ACCESS, bSel and bWrite SHALL be 0; bAddr, bWData, mem_size SHALL hold their last values.
REQ-026 resp_rdata SHALL be 0 for stores and errored requests; resp_err SHALL be 0 whenever resp_valid=0.
REQ-027 req_* inputs changing after acceptance SHALL not affect the transaction in flight.

Reset
REQ-028 rst SHALL force IDLE, counter 0, and all outputs 0 except req_ready=1 on the following cycle.
REQ-029 rst asserted during ACCESS or RESP SHALL abort the transaction with no resp_valid pulse; bSel SHALL be 0 from the next edge.

Configuration
REQ-030 Macro LOAD_SIGNEXT_EN defined: byte/half loads with registered req_signed=1 SHALL sign-extend from bit 7/15; not defined: req_signed SHALL be ignored and loads SHALL always zero-extend.

Verification
REQ-031 WAIT_CYCLES=0, load word addr 0x10, bRData=0x12345678 -> bSel high exactly 1 cycle, resp_valid 2 cycles after accept, resp_rdata=0x12345678, resp_err=0.
REQ-032 Store byte addr 0x4, wdata=0xAB -> bWData=0xABABABAB, bWrite=1, mem_size=10 for one cycle, resp_rdata=0.
REQ-033 Load half addr 0x3 -> no bSel, resp_valid next cycle after accept, resp_err=1; req_size=11 likewise.
REQ-034 LOAD_SIGNEXT_EN, req_signed=1, load byte, bRData=0x00000080 -> resp_rdata=0xFFFFFF80; without macro -> 0x00000080.
REQ-035 WAIT_CYCLES=3, load word -> bSel high 4 cycles, bRData sampled in 4th; rst in 2nd ACCESS cycle -> no resp_valid, req_ready=1 after reset.

Source files
------------

// File: rtl/bus_master.sv
// Single-beat bus master: one request at a time, size/alignment check, lane replication on stores.
// Optional LOAD_SIGNEXT_EN: sign-extend byte/half loads when the registered req_signed is set.
//
// state  | meaning
// IDLE   | req_ready high, waiting for req_valid
// ACCESS | bSel high for WAIT_CYCLES+1 cycles, read data captured in the last one
// RESP   | one-cycle resp_valid pulse
module bus_master #(
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bSel,
    output logic        bWrite,
    output logic [31:0] bAddr,
    output logic [31:0] bWData,
    output logic [1:0]  mem_size,
    input  logic [31:0] bRData
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        write_q;
    logic        err_q;
    logic        signed_q;
    logic [31:0] rdata_q;
    logic        accept;
    logic        illegal;

    function automatic logic [31:0] fmt_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b01:   r = {d[15:0], d[15:0]};
            2'b10:   r = {4{d[7:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Narrow loads come back right-justified; upper bits are zero or copies of the sign bit.
    function automatic logic [31:0] ext_rdata(input logic [1:0] size, input logic sgn,
                                              input logic [31:0] d);
        logic [31:0] r;
        case (size)
            2'b10:   r = {{24{sgn & d[7]}}, d[7:0]};
            2'b01:   r = {{16{sgn & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign illegal = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b00) & (|req_addr[1:0]));
    assign accept  = req_valid & (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        bSel       = 1'b0;
        bWrite     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                bSel   = 1'b1;
                bWrite = write_q;
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'd0;

`ifdef LOAD_SIGNEXT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            signed_q <= 1'b0;
        end else if (accept) begin
            signed_q <= req_signed;
        end
    end
`else
    logic unused_req_signed;
    assign unused_req_signed = req_signed;
    assign signed_q          = 1'b0;
`endif

    // Bus address/data/size only move on a legal acceptance so they hold across errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
            bAddr    <= 32'd0;
            bWData   <= 32'd0;
            mem_size <= 2'b00;
        end else if (accept) begin
            cnt     <= WAIT_LOAD;
            write_q <= req_write;
            err_q   <= illegal;
            rdata_q <= 32'd0;
            if (!illegal) begin
                bAddr    <= req_addr;
                bWData   <= fmt_wdata(req_size, req_wdata);
                mem_size <= req_size;
            end
        end else if (state == ACCESS) begin
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else if (!write_q) begin
                rdata_q <= ext_rdata(mem_size, signed_q, bRData);
            end
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: two instances (WAIT_CYCLES 0 and 3), vector table plus reset-abort sequence.
// Expected responses go through a scoreboard queue; sign-extension expectations follow LOAD_SIGNEXT_EN.
module tb_bus_master;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_bwdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } resp_t;

`ifdef LOAD_SIGNEXT_EN
    localparam logic [31:0] SX_B = 32'hFFFF_FF80;
    localparam logic [31:0] SX_H = 32'hFFFF_9001;
`else
    localparam logic [31:0] SX_B = 32'h0000_0080;
    localparam logic [31:0] SX_H = 32'h0000_9001;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rv;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [1:0]  ready, resp_valid, resp_err, bsel, bwrite;
    logic [31:0] resp_rdata [2];
    logic [31:0] baddr [2];
    logic [31:0] bwdata [2];
    logic [1:0]  msize [2];
    logic [31:0] brdata [2];

    int    n_checks = 0;
    int    n_fail   = 0;
    resp_t sbq[$];
    vec_t  vecs[13];

    always #5 clk = ~clk;

    bus_master #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(ready[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_signed(req_signed),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .bSel(bsel[0]), .bWrite(bwrite[0]), .bAddr(baddr[0]), .bWData(bwdata[0]),
        .mem_size(msize[0]), .bRData(brdata[0])
    );

    bus_master #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(ready[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_size(req_size), .req_signed(req_signed),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .bSel(bsel[1]), .bWrite(bwrite[1]), .bAddr(baddr[1]), .bWData(bwdata[1]),
        .mem_size(msize[1]), .bRData(brdata[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] bus, input logic exp_err,
                                input logic [31:0] exp_rdata, input logic [31:0] exp_bwdata);
        vec_t v;
        v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.bus = bus; v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_bwdata = exp_bwdata;
        return v;
    endfunction

    task automatic check_idle_outputs(input int d, input string tag);
        check({tag, "_ready"}, 32'(ready[d]), 32'd1);
        check({tag, "_bsel"}, 32'(bsel[d]), 32'd0);
        check({tag, "_bwrite"}, 32'(bwrite[d]), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err[d]), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata[d], 32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the response.
    task automatic run(input int d, input vec_t v, input int w);
        int    nsel = 0;
        int    done = 0;
        resp_t r;
        check("ready_before_req", 32'(ready[d]), 32'd1);
        req_write  = v.wr;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_size   = v.size;
        req_signed = v.sgn;
        brdata[d]  = 32'hDEAD_0000;
        rv[d]      = 1'b1;
        @(posedge clk);
        sbq.push_back('{err: v.exp_err, rdata: v.exp_rdata});
        @(negedge clk);
        rv[d]      = 1'b0;
        req_write  = ~v.wr;
        req_addr   = 32'hFFFF_FFFC;
        req_wdata  = ~v.wdata;
        req_size   = ~v.size;
        req_signed = ~v.sgn;
        for (int cyc = 1; cyc <= 24 && done == 0; cyc++) begin
            if (bsel[d]) begin
                nsel++;
                brdata[d] = (nsel == w + 1) ? v.bus : 32'h5A5A_5A5A;
                check("bus_addr", baddr[d], v.addr);
                check("bus_size", 32'(msize[d]), 32'(v.size));
                check("bus_write", 32'(bwrite[d]), 32'(v.wr));
                check("ready_busy", 32'(ready[d]), 32'd0);
                if (v.wr) check("bus_wdata", bwdata[d], v.exp_bwdata);
            end
            if (resp_valid[d]) begin
                done = 1;
                check("resp_latency", 32'(cyc), v.exp_err ? 32'd1 : 32'(w + 2));
                check("bsel_cycles", 32'(nsel), v.exp_err ? 32'd0 : 32'(w + 1));
                if (sbq.size() > 0) begin
                    r = sbq.pop_front();
                    check("resp_rdata", resp_rdata[d], r.rdata);
                    check("resp_err", 32'(resp_err[d]), 32'(r.err));
                end else begin
                    check("scoreboard_empty", 32'd0, 32'd1);
                end
            end
            @(negedge clk);
        end
        if (done == 0) begin
            check("resp_timeout", 32'd0, 32'd1);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end
        check_idle_outputs(d, "after_resp");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk(1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'h1234_5678, 1'b0, 32'h1234_5678, 32'h0);
        vecs[1]  = mk(1'b1, 2'b10, 1'b0, 32'h4,  32'hAB,       32'hFFFF_FFFF, 1'b0, 32'h0,         32'hABAB_ABAB);
        vecs[2]  = mk(1'b0, 2'b01, 1'b0, 32'h3,  32'h0,        32'h1111_1111, 1'b1, 32'h0,         32'h0);
        vecs[3]  = mk(1'b0, 2'b11, 1'b0, 32'h8,  32'h0,        32'h1111_1111, 1'b1, 32'h0,         32'h0);
        vecs[4]  = mk(1'b0, 2'b10, 1'b1, 32'h5,  32'h0,        32'h0000_0080, 1'b0, SX_B,          32'h0);
        vecs[5]  = mk(1'b0, 2'b01, 1'b0, 32'h2,  32'h0,        32'hCAFE_8001, 1'b0, 32'h0000_8001, 32'h0);
        vecs[6]  = mk(1'b1, 2'b01, 1'b0, 32'h6,  32'h1234_BEEF, 32'h0,        1'b0, 32'h0,         32'hBEEF_BEEF);
        vecs[7]  = mk(1'b1, 2'b00, 1'b0, 32'h20, 32'hA5A5_0F0F, 32'h0,        1'b0, 32'h0,         32'hA5A5_0F0F);
        vecs[8]  = mk(1'b0, 2'b00, 1'b0, 32'h2,  32'h0,        32'h7777_7777, 1'b1, 32'h0,         32'h0);
        vecs[9]  = mk(1'b0, 2'b10, 1'b0, 32'h7,  32'h0,        32'h1234_56F0, 1'b0, 32'h0000_00F0, 32'h0);
        vecs[10] = mk(1'b0, 2'b01, 1'b1, 32'hA,  32'h0,        32'h0000_9001, 1'b0, SX_H,          32'h0);
        vecs[11] = mk(1'b1, 2'b10, 1'b0, 32'h3,  32'h1CD,      32'h0,         1'b0, 32'h0,         32'hCDCD_CDCD);
        vecs[12] = mk(1'b1, 2'b01, 1'b0, 32'h1,  32'h55,       32'h0,         1'b1, 32'h0,         32'h0);

        rst = 1'b1; rv = 2'b00;
        req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'b00; req_signed = 1'b0;
        brdata[0] = 32'h0; brdata[1] = 32'h0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_idle_outputs(d, "reset");
            check("reset_baddr", baddr[d], 32'h0);
            check("reset_bwdata", bwdata[d], 32'h0);
            check("reset_msize", 32'(msize[d]), 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back on the zero-wait instance: each call starts on the cycle after RESP.
        for (int i = 0; i < 13; i++) run(0, vecs[i], 0);
        // Errored request leaves the bus fields from the last legal access.
        check("err_holds_baddr", baddr[0], 32'h3);
        check("err_holds_bwdata", bwdata[0], 32'hCDCD_CDCD);

        run(1, vecs[0], 3);
        run(1, vecs[4], 3);
        run(1, vecs[1], 3);
        run(1, vecs[3], 3);

        // Reset during the second ACCESS cycle aborts with no response.
        req_write = 1'b0; req_addr = 32'h40; req_size = 2'b00; req_signed = 1'b0;
        brdata[1] = 32'h0BAD_0BAD;
        rv[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rv[1] = 1'b0;
        check("abort_access1_bsel", 32'(bsel[1]), 32'd1);
        @(negedge clk);
        check("abort_access2_bsel", 32'(bsel[1]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs(1, "abort");
        check("abort_baddr", baddr[1], 32'h0);
        check("abort_msize", 32'(msize[1]), 32'h0);
        begin
            int pulses = 0;
            for (int i = 0; i < 8; i++) begin
                if (resp_valid[1] || bsel[1]) pulses++;
                @(negedge clk);
            end
            check("abort_no_activity", 32'(pulses), 32'd0);
        end
        run(1, vecs[5], 3);
        run(0, vecs[0], 0);

        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
